// File: rtl/program_loader_pkg.sv
// Shared loader definitions: FSM state encodings
// and the instruction word width.
package program_loader_pkg;

  localparam int INSN_WIDTH = 28;

  typedef enum logic [2:0] {
    LDR_HDR_HI,
    LDR_HDR_LO,
    LDR_WORD,
    LDR_WRITE,
    LDR_DONE,
    LDR_ERROR
  } ldr_state_e;

endpackage

// File: rtl/loader_word_assembler.sv
// Big-endian 4-byte shift register for one instruction
// word; the top nibble of byte 0 is checked, never stored.
module loader_word_assembler
  import program_loader_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  shift,
  input  logic [7:0]            data,
  output logic [INSN_WIDTH-1:0] word,
  output logic [1:0]            index,
  output logic                  last,
  output logic                  nibble_error
);

  // shift accepted bytes in, wrapping the index every 4 bytes
  always_ff @(posedge clk) begin
    if (rst) begin
      word  <= '0;
      index <= '0;
    end else if (shift) begin
      word  <= {word[INSN_WIDTH-9:0], data};
      index <= index + 2'd1;
    end
  end

  assign last         = shift && (index == 2'd3);
  assign nibble_error = shift && (index == 2'd0)
                        && (data[7:4] != 4'h0);

endmodule

// File: rtl/program_loader.sv
// Streams a length-prefixed byte image into instruction RAM
// and holds the core in reset until the load completes.
module program_loader
  import program_loader_pkg::*;
#(
  parameter int ADDR_WIDTH = 16,
  parameter int DEPTH      = 256
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic [7:0]            iByte,
  input  logic                  iByteValid,
  output logic                  oByteReady,
  output logic                  oWriteEnable,
  output logic [ADDR_WIDTH-1:0] oWriteAddress,
  output logic [INSN_WIDTH-1:0] oInstruction,
  output logic                  oCpuReset,
  output logic                  oLoadDone,
  output logic                  oError
);

  ldr_state_e state;
  ldr_state_e state_next;

  logic [15:0] length;
  logic [15:0] count;
  logic [15:0] count_inc;
  logic [15:0] hdr_length;
  logic        ready;
  logic        xfer;
  logic        shift;
  logic        last;
  logic        nibble_error;
  logic [1:0]  index;

  assign xfer       = iByteValid && oByteReady;
  assign shift      = xfer && (state == LDR_WORD);
  assign hdr_length = {length[15:8], iByte};
  assign count_inc  = count + 16'd1;

  assign oByteReady    = ready && !Reset;
  assign oWriteEnable  = (state == LDR_WRITE) && !Reset;
  assign oWriteAddress = ADDR_WIDTH'(count);

  loader_word_assembler u_asm (
    .clk          (Clock),
    .rst          (Reset),
    .shift        (shift),
    .data         (iByte),
    .word         (oInstruction),
    .index        (index),
    .last         (last),
    .nibble_error (nibble_error)
  );

  // state, header length and written-word count
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state  <= LDR_HDR_HI;
      length <= '0;
      count  <= '0;
    end else begin
      state <= state_next;
      if (xfer && state == LDR_HDR_HI)
        length[15:8] <= iByte;
      if (xfer && state == LDR_HDR_LO)
        length[7:0] <= iByte;
      if (state == LDR_WRITE)
        count <= count_inc;
    end
  end

  // status flags lag the state by one cycle so the core
  // only ever sees clean register outputs
  always_ff @(posedge Clock) begin
    if (Reset) begin
      oCpuReset <= 1'b1;
      oLoadDone <= 1'b0;
      oError    <= 1'b0;
    end else begin
      oCpuReset <= (state != LDR_DONE);
      oLoadDone <= (state == LDR_DONE);
      oError    <= (state == LDR_ERROR);
    end
  end

  // next-state and byte-ready decode
  always_comb begin
    state_next = state;
    ready      = 1'b0;
    unique case (state)
      LDR_HDR_HI: begin
        ready = 1'b1;
        if (xfer)
          state_next = LDR_HDR_LO;
      end
      LDR_HDR_LO: begin
        ready = 1'b1;
        if (xfer) begin
          if (hdr_length == 16'd0)
            state_next = LDR_DONE;
          else if (hdr_length > 16'(DEPTH))
            state_next = LDR_ERROR;
          else
            state_next = LDR_WORD;
        end
      end
      LDR_WORD: begin
        ready = 1'b1;
        if (nibble_error)
          state_next = LDR_ERROR;
        else if (last)
          state_next = LDR_WRITE;
      end
      LDR_WRITE: begin
        if (count_inc == length)
          state_next = LDR_DONE;
        else
          state_next = LDR_WORD;
      end
      LDR_DONE:  state_next = LDR_DONE;
      LDR_ERROR: state_next = LDR_ERROR;
      default:   state_next = LDR_ERROR;
    endcase
  end

  logic unused;
  assign unused = ^index;

endmodule
